cnn_mem_arbiter: RTL and testbench

//  Shares the single result-memory port (csel/cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd) among
//  NUM_REQ engines: conv kernel0, conv kernel1, max-pool, flatten. Issues one access per cycle.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/cnn_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cnn_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN result-memory datapath.
//  - memory-select (csel) encodings
//  - default address / data / select widths of the result-memory port
//  - arbiter FSM state type
package cnn_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 20;
    localparam int MEM_SEL_W  = 3;

    // Target memory select; NO_MEM marks a request that must not touch memory.
    typedef enum logic [MEM_SEL_W-1:0] {
        NO_MEM = 3'd0,
        L0_K0  = 3'd1,
        L0_K1  = 3'd2,
        L1_K0  = 3'd3,
        L1_K1  = 3'd4,
        L2     = 3'd5
    } csel_e;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//  Scans req starting at index ptr (wrapping) and selects the first set bit.
// Ports:
//  req        in   NUM_REQ  request vector
//  ptr        in   IDX_W    index with highest priority this cycle
//  grant      out  NUM_REQ  one-hot winner (0 when no request)
//  grant_idx  out  IDX_W    index of the winner (0 when no request)
//  any        out  1        at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop; without it the
        // "no request" path would hold the old value and infer a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cnn_mem_arbiter.sv
// Shares the single result-memory port among NUM_REQ engines
// (conv kernel0, conv kernel1, max-pool, flatten), one access per cycle.
// Round-robin arbitration with an optional bounded lock for bursts, and
// routing of read data back to the requester that issued the read.
// Ports:
//  clk, reset                 clock (rising edge), async active-high reset
//  req_valid/we/lock          per-requester request, direction, burst lock
//  req_sel/addr/wdata         per-requester target, address, write data (packed)
//  grant                      one-hot combinational accept
//  rd_valid, rd_data          read return: owner strobe and broadcast data
//  csel, cwr, crd             registered memory select and strobes
//  caddr_wr, caddr_rd         registered write / read address
//  cdata_wr, cdata_rd         registered write data / memory read data
//  sel_err                    sticky: a granted request carried select 0
module cnn_mem_arbiter
    import cnn_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int SEL_W    = MEM_SEL_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [SEL_W-1:0]          csel,
    output logic                      cwr,
    output logic                      crd,
    output logic [ADDR_W-1:0]         caddr_wr,
    output logic [ADDR_W-1:0]         caddr_rd,
    output logic [DATA_W-1:0]         cdata_wr,
    input  logic [DATA_W-1:0]         cdata_rd,
    output logic                      sel_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;

    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic [NUM_REQ-1:0] grant_int;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;

    // Owner of the read currently on crd, and the return pipe behind it.
    logic [IDX_W-1:0]   rd_owner;
    logic               pipe_vld [RD_LAT];
    logic [IDX_W-1:0]   pipe_own [RD_LAT];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Next-state / grant decision.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        grant_int    = '0;
        win_valid    = 1'b0;
        win_idx      = rr_idx;

        case (state)
            ARB: begin
                if (rr_any) begin
                    grant_int  = rr_grant;
                    win_valid  = 1'b1;
                    win_idx    = rr_idx;
                    rr_ptr_nxt = (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
                    // A lock limit of one grant means the burst is already complete.
                    if (req_lock[rr_idx] && MAX_LOCK > 1) begin
                        state_nxt    = LOCKED;
                        owner_nxt    = rr_idx;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (req_valid[owner]) begin
                    grant_int        = '0;
                    grant_int[owner] = 1'b1;
                    win_valid        = 1'b1;
                    win_idx          = owner;
                    lock_cnt_nxt     = lock_cnt + 1'b1;
                    if (!req_lock[owner] || lock_cnt_nxt == CNT_W'(MAX_LOCK)) begin
                        state_nxt    = ARB;
                        lock_cnt_nxt = '0;
                    end
                end else begin
                    // Owner dropped its request: release without granting anyone.
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    assign grant = reset ? '0 : grant_int;

    logic              win_we;
    logic [SEL_W-1:0]  win_sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign win_we    = req_we[win_idx];
    assign win_sel   = req_sel[win_idx*SEL_W +: SEL_W];
    assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
            csel     <= '0;
            cwr      <= 1'b0;
            crd      <= 1'b0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            sel_err  <= 1'b0;
            rd_owner <= '0;
            // NOTE: the owner pipe is reset (unlike a data memory) because a
            // stale valid bit would return data for a read dropped by reset.
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_own[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every register samples the
            // pre-edge values regardless of statement order.
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;

            cwr <= 1'b0;
            crd <= 1'b0;
            if (win_valid) begin
                if (win_sel == SEL_W'(NO_MEM)) begin
                    sel_err <= 1'b1;
                end else begin
                    csel <= win_sel;
                    if (win_we) begin
                        cwr      <= 1'b1;
                        caddr_wr <= win_addr;
                        cdata_wr <= win_wdata;
                    end else begin
                        crd      <= 1'b1;
                        caddr_rd <= win_addr;
                        rd_owner <= win_idx;
                    end
                end
            end

            // Stage 0 captures the read on crd, so the last stage lines up
            // with cdata_rd RD_LAT cycles after the strobe.
            pipe_vld[0] <= crd;
            pipe_own[0] <= rd_owner;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_own[s] <= pipe_own[s-1];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (pipe_vld[RD_LAT-1]) rd_valid[pipe_own[RD_LAT-1]] = 1'b1;
    end

    assign rd_data = cdata_rd;

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
module tb_cnn_mem_arbiter;
    import cnn_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 20;
    localparam int SEL_W    = 3;
    localparam int RD_LAT   = 1;
    localparam int MAX_LOCK = 16;

    typedef struct {
        bit                we;
        bit                lock;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } tx_t;

    typedef struct {
        int                cyc;
        bit                we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    typedef struct {
        int                cyc;
        int                owner;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid, req_we, req_lock;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        grant, rd_valid;
    logic [DATA_W-1:0]         rd_data, cdata_wr, cdata_rd;
    logic [SEL_W-1:0]          csel;
    logic                      cwr, crd, sel_err;
    logic [ADDR_W-1:0]         caddr_wr, caddr_rd;

    cnn_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SEL_W(SEL_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data),
        .csel(csel), .cwr(cwr), .crd(crd),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural memory behind the port: registered read, RD_LAT = 1.
    logic [DATA_W-1:0] mem_dut [int];
    function automatic int key(input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a);
        return (int'(s) << ADDR_W) | int'(a);
    endfunction

    always @(posedge clk) begin
        if (crd) cdata_rd <= mem_dut.exists(key(csel, caddr_rd)) ? mem_dut[key(csel, caddr_rd)] : '0;
        if (cwr) mem_dut[key(csel, caddr_wr)] = cdata_wr;
    end

    // Reference model: pending transactions, arbitration rules, expected results.
    tx_t               txq [NUM_REQ][$];
    op_t               exp_ops [$];
    rd_t               exp_rd [$];
    logic [DATA_W-1:0] mem_model [int];
    int                m_ptr;
    bit                m_locked;
    int                m_owner;
    int                m_cnt;
    bit                m_sel_err;

    function automatic void model_reset();
        m_ptr     = 0;
        m_locked  = 0;
        m_owner   = 0;
        m_cnt     = 0;
        m_sel_err = 0;
        exp_ops.delete();
        exp_rd.delete();
        for (int i = 0; i < NUM_REQ; i++) txq[i].delete();
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (txq[i].size() > 0) return 1;
        return 0;
    endfunction

    // One clock of stimulus: present queue heads, predict the grant, update the model.
    task automatic tick();
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] exp_g;
        int                 w;
        tx_t                t;
        int                 k;
        @(negedge clk);
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (txq[i].size() > 0) begin
                t = txq[i][0];
                v[i] = 1'b1;
                req_we[i]   = t.we;
                req_lock[i] = t.lock;
                req_sel[i*SEL_W +: SEL_W]    = t.sel;
                req_addr[i*ADDR_W +: ADDR_W] = t.addr;
                req_wdata[i*DATA_W +: DATA_W] = t.data;
            end else begin
                req_lock[i] = 1'b0;
            end
        end
        req_valid = v;
        #1;
        w = -1;
        if (m_locked) begin
            if (v[m_owner]) w = m_owner;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (w < 0 && v[(m_ptr + j) % NUM_REQ]) w = (m_ptr + j) % NUM_REQ;
            end
        end
        exp_g = '0;
        if (w >= 0) exp_g[w] = 1'b1;
        check("grant", 64'(grant), 64'(exp_g));

        if (m_locked) begin
            if (w < 0) m_locked = 0;
            else begin
                m_cnt++;
                if (!txq[w][0].lock || m_cnt == MAX_LOCK) m_locked = 0;
            end
        end else if (w >= 0) begin
            m_ptr = (w + 1) % NUM_REQ;
            if (txq[w][0].lock) begin
                m_locked = 1;
                m_owner  = w;
                m_cnt    = 1;
            end
        end

        if (w >= 0) begin
            t = txq[w].pop_front();
            if (t.sel == '0) m_sel_err = 1;
            else begin
                exp_ops.push_back('{cyc + 1, t.we, t.sel, t.addr, t.data});
                k = key(t.sel, t.addr);
                if (t.we) mem_model[k] = t.data;
                else exp_rd.push_back('{cyc + 1 + RD_LAT, w, mem_model.exists(k) ? mem_model[k] : '0});
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        repeat (RD_LAT + 3) tick();
        check("leftover_tx", 64'(pending()), 64'(0));
        check("leftover_ops", 64'(exp_ops.size() + exp_rd.size()), 64'(0));
    endtask

    function automatic tx_t mk(input bit we, input bit lock, input logic [SEL_W-1:0] sel,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        tx_t t;
        t.we = we; t.lock = lock; t.sel = sel; t.addr = addr; t.data = data;
        return t;
    endfunction

    function automatic tx_t rand_tx(input bit lock);
        logic [SEL_W-1:0] s;
        s = ($urandom_range(0, 15) == 0) ? SEL_W'(0) : SEL_W'($urandom_range(1, 5));
        return mk(1'($urandom_range(0, 1)), lock, s, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
    endfunction

    // Monitor: pops expectations whenever the DUT presents a strobe or read return.
    bit  running = 0;
    op_t mop;
    rd_t mrd;

    always @(negedge clk) begin
        if (!reset && running) begin
            while (exp_ops.size() > 0 && exp_ops[0].cyc < cyc) begin
                mop = exp_ops.pop_front();
                check("op_missing_cycle", 64'(cyc), 64'(mop.cyc));
            end
            while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
                mrd = exp_rd.pop_front();
                check("rd_missing_cycle", 64'(cyc), 64'(mrd.cyc));
            end
            if (cwr || crd) begin
                if (exp_ops.size() == 0) check("op_unexpected", 64'({cwr, crd}), 64'(0));
                else begin
                    mop = exp_ops.pop_front();
                    check("op_cycle", 64'(cyc), 64'(mop.cyc));
                    check("op_kind", 64'({cwr, crd}), mop.we ? 64'(2) : 64'(1));
                    check("csel", 64'(csel), 64'(mop.sel));
                    if (mop.we) begin
                        check("caddr_wr", 64'(caddr_wr), 64'(mop.addr));
                        check("cdata_wr", 64'(cdata_wr), 64'(mop.data));
                    end else begin
                        check("caddr_rd", 64'(caddr_rd), 64'(mop.addr));
                    end
                end
            end
            if (rd_valid != '0) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'(0));
                else begin
                    mrd = exp_rd.pop_front();
                    check("rd_cycle", 64'(cyc), 64'(mrd.cyc));
                    check("rd_valid", 64'(rd_valid), 64'(1) << mrd.owner);
                    check("rd_data", 64'(rd_data), 64'(mrd.data));
                end
            end
            check("sel_err", 64'(sel_err), 64'(m_sel_err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0;
        req_sel = '0; req_addr = '0; req_wdata = '0;
        cdata_rd = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({grant, rd_valid, csel, cwr, crd, caddr_wr, caddr_rd, cdata_wr, sel_err}), 64'(0));
        reset = 1'b0;
        running = 1;

        // Single write on requester 0.
        txq[0].push_back(mk(1, 0, L0_K0, 12'h005, 20'h01234));
        run_until_idle(10);

        // All four requesting continuously, no lock: strict rotation.
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 8; j++) txq[i].push_back(rand_tx(0));
        run_until_idle(100);

        // Align the pointer to 2, then a pool burst of four locked reads with others pending.
        txq[1].push_back(mk(1, 0, L1_K0, 12'h040, 20'hABCDE));
        run_until_idle(10);
        txq[2].push_back(mk(0, 1, L1_K0, 12'h000, '0));
        txq[2].push_back(mk(0, 1, L1_K0, 12'h001, '0));
        txq[2].push_back(mk(0, 1, L1_K0, 12'h040, '0));
        txq[2].push_back(mk(0, 0, L1_K0, 12'h041, '0));
        txq[0].push_back(rand_tx(0));
        txq[1].push_back(rand_tx(0));
        txq[3].push_back(rand_tx(0));
        run_until_idle(40);

        // Lock held forever: forced release after MAX_LOCK grants.
        for (int j = 0; j < 20; j++) txq[3].push_back(mk(1, 1, L2, ADDR_W'(j), DATA_W'(j * 7 + 1)));
        tick();
        txq[0].push_back(rand_tx(0));
        txq[1].push_back(rand_tx(0));
        run_until_idle(60);

        // Select 0 read: no strobe, sticky error; then a normal read completes.
        txq[1].push_back(mk(0, 0, SEL_W'(NO_MEM), 12'h003, '0));
        txq[1].push_back(mk(0, 0, L1_K0, 12'h041, '0));
        run_until_idle(20);

        // Randomized traffic with occasional bursts, including over-long ones.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (txq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    len = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 5);
                    for (int j = 0; j < len; j++) txq[i].push_back(rand_tx(j < len - 1));
                end
            end
            tick();
        end
        run_until_idle(500);

        // Reset one cycle after a crd pulse: in-flight read is dropped.
        txq[1].push_back(mk(0, 0, L0_K1, 12'h007, '0));
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        check("midreset_outputs", 64'({grant, rd_valid, csel, cwr, crd, caddr_wr, caddr_rd, cdata_wr, sel_err}), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) tick();

        // Normal traffic after reset.
        txq[2].push_back(mk(1, 0, L2, 12'h0AA, 20'h55555));
        txq[0].push_back(mk(0, 0, L2, 12'h0AA, '0));
        run_until_idle(20);

        running = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
